fir_serial_mac: RTL and testbench
=================================

Name: fir_serial_mac

Overview:
Parametrised single-channel FIR filter for the audio path. It uses one time-multiplexed multiply-accumulate unit instead of a fully parallel tap array. Coefficients are run-time loadable through a register-write port. The block sits between the audio sample source and the FFT/HDMI display chain. It keeps the en/xin/valid/yout sample-interface style and adds a ready back-pressure signal.

Parameters:
DW, 16, input sample width (signed two's complement)
CW, 12, coefficient width (signed two's complement)
NTAP, 16, number of taps; minimum 2; need not be a power of two
AW, $clog2(NTAP), coefficient address width (localparam, derived)
OW, DW+CW+$clog2(NTAP), output/accumulator width (localparam, derived; 32 at defaults)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
en  in  1  input sample strobe; a sample is taken when en && rdy at a rising clk edge
xin  in  DW  signed input sample
rdy  out  1  block can accept a sample this cycle
coef_we  in  1  coefficient write strobe
coef_addr  in  AW  tap index k to write
coef_din  in  CW  signed coefficient value h[k]
valid  out  1  one-cycle pulse; yout holds a new result
yout  out  OW  signed filter output, y[n] = sum over k=0..NTAP-1 of h[k]*x[n-k]

Behaviour:
- Reset (asynchronous, rstn=0):
  - state=IDLE, rdy=1 after release, valid=0, yout=0, acc=0, tap counter=0, write pointer=0.
  - All delay-line entries and all coefficients are cleared to 0, so coefficients must be reloaded after any reset.
- States:
  - IDLE: rdy=1.
  - MAC: rdy=0.
- IDLE transition, at an edge with en=1:
  - xin is written to the delay line at wptr.
  - wptr advances modulo NTAP; NTAP-1 wraps to 0.
  - acc clears, k=0, state goes to MAC.
  - en=0 holds IDLE.
- MAC, one tap per edge:
  - acc_next = acc + x[(newest - k) mod NTAP] * h[k].
  - If k == NTAP-1: yout <= acc_next, valid <= 1 for exactly one cycle, state goes to IDLE.
  - Otherwise k increments.
- Latency: the accept edge is E0. MAC runs at edges E1..E_NTAP. valid is high in the cycle after E_NTAP.
  - Minimum sample period is NTAP+1 cycles.
  - With en held high, samples are accepted every NTAP+1 cycles.
- Back-pressure: en and xin are ignored while rdy=0. No sample is queued.
- yout holds its last value between valid pulses.
- Arithmetic:
  - Product is signed, DW+CW bits.
  - Accumulator is signed, OW bits. Overflow is impossible by construction, so there is no saturation or rounding.
- Coefficient writes:
  - Applied only while state=IDLE. Writes during MAC are dropped silently, so a result never mixes old and new coefficients.
  - coef_addr >= NTAP: the write is ignored.
  - coef_we and an accepted en at the same IDLE edge: both take effect, and the new sample's computation uses the newly written coefficient.
- Reset during MAC aborts the computation: no valid pulse and no partial yout.

Decomposition:
- Shared package fir_pkg holds:
  - state enum {IDLE, MAC}
  - width helper function acc_width(DW, CW, NTAP)
- One sub-module, fir_coef_bank:
  - NTAP×CW register file
  - gated write port (we && idle && addr<NTAP)
  - combinational read mux on k
  - asynchronous clear
- Delay line, FSM and MAC stay in the top module.

Test Plan:
1. Reset check: assert rstn=0 mid-run, then release. Required: valid=0, yout=0, rdy=1. A following impulse with no coefficient reload gives yout=0 for all outputs.
2. Impulse response (defaults): load h[k]=k+1, feed xin=1000, then zeros. Required: yout sequence 1000, 2000, …, 16000, then 0. Each valid comes exactly 16 edges after its accept edge.
3. Streaming: hold en=1 with xin incrementing every cycle. Required:
   - accepts occur exactly every 17 cycles;
   - rdy is low for 16 cycles after each accept;
   - the skipped xin values never appear in results.
4. Full-scale: all h=-2048, constant xin=-32768. Required: after the 16th valid, yout=1073741824 with no wrap. Also h=2047 with xin=-32768 must give yout=-1073217536.
5. Coefficient timing: a write issued during MAC is ignored, so the next result is unchanged. A write coinciding with an accept in IDLE is used by that sample's result.
6. Wrap and reset (NTAP=5 instance): run 12 impulses at varying spacing and compare against a reference model across wptr wraparound. Then pull rstn low at k=2 of a MAC. Required: no valid pulse, and rdy=1 after release.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and width helpers for the serial-MAC FIR filter.
package fir_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MAC  = 1'b1
  } state_e;

  function automatic int acc_width(int dw, int cw, int ntap);
    return dw + cw + $clog2(ntap);
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Run-time loadable coefficient register file, written only while idle.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int CW   = 12,
  parameter int NTAP = 16,
  parameter int AW   = $clog2(NTAP)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 we_i,
  input  logic                 idle_i,
  input  logic [AW-1:0]        addr_i,
  input  logic signed [CW-1:0] din_i,
  input  logic [AW-1:0]        rk_i,
  output logic signed [CW-1:0] h_o
);

  localparam logic [AW:0] NT = (AW+1)'(NTAP);

  logic signed [CW-1:0] mem_q [NTAP];
  logic                 wr_en;

  // Writes during MAC are dropped so one result never mixes coefficient sets.
  assign wr_en = we_i && idle_i && ({1'b0, addr_i} < NT);
  assign h_o   = mem_q[rk_i];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NTAP; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[addr_i] <= din_i;
    end
  end

endmodule

// File: rtl/fir_serial_mac.sv
// Single-channel FIR filter using one time-multiplexed multiply-accumulate.
module fir_serial_mac
  import fir_pkg::*;
#(
  parameter  int DW   = 16,
  parameter  int CW   = 12,
  parameter  int NTAP = 16,
  localparam int AW   = $clog2(NTAP),
  localparam int OW   = acc_width(DW, CW, NTAP)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic signed [DW-1:0] xin,
  output logic                 rdy,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_din,
  output logic                 valid,
  output logic signed [OW-1:0] yout
);

  localparam int          PW    = DW + CW;
  localparam logic [AW-1:0] KLAST = AW'(NTAP - 1);
  localparam logic [AW:0] NT    = (AW+1)'(NTAP);

  state_e               state_q, state_d;
  logic [AW-1:0]        k_q, k_d;
  logic [AW-1:0]        wptr_q, wptr_d;
  logic [AW-1:0]        newest_q, newest_d;
  logic signed [OW-1:0] acc_q, acc_d;
  logic signed [OW-1:0] yout_q, yout_d;
  logic                 valid_q, valid_d;
  logic signed [DW-1:0] x_q [NTAP];

  logic [AW:0]          diff, dwrap;
  logic [AW-1:0]        rd_idx;
  logic signed [CW-1:0] h_k;
  logic signed [PW-1:0] xe, he, prod;
  logic signed [OW-1:0] acc_nx;
  logic                 accept;

  assign rdy    = (state_q == IDLE);
  assign accept = rdy && en;
  assign valid  = valid_q;
  assign yout   = yout_q;

  // Circular read index (newest - k) mod NTAP, valid for any NTAP.
  assign diff   = {1'b0, newest_q} - {1'b0, k_q};
  assign dwrap  = diff + NT;
  assign rd_idx = (newest_q >= k_q) ? diff[AW-1:0] : dwrap[AW-1:0];

  assign xe     = PW'(x_q[rd_idx]);
  assign he     = PW'(h_k);
  assign prod   = xe * he;
  assign acc_nx = acc_q + {{(OW-PW){prod[PW-1]}}, prod};

  fir_coef_bank #(
    .CW   (CW),
    .NTAP (NTAP),
    .AW   (AW)
  ) u_coef (
    .clk    (clk),
    .rstn   (rstn),
    .we_i   (coef_we),
    .idle_i (rdy),
    .addr_i (coef_addr),
    .din_i  (coef_din),
    .rk_i   (k_q),
    .h_o    (h_k)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    wptr_d   = wptr_q;
    newest_d = newest_q;
    acc_d    = acc_q;
    yout_d   = yout_q;
    valid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          newest_d = wptr_q;
          wptr_d   = (wptr_q == KLAST) ? '0 : wptr_q + 1'b1;
          acc_d    = '0;
          k_d      = '0;
          state_d  = MAC;
        end
      end
      MAC: begin
        acc_d = acc_nx;
        if (k_q == KLAST) begin
          yout_d  = acc_nx;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      k_q      <= '0;
      wptr_q   <= '0;
      newest_q <= '0;
      acc_q    <= '0;
      yout_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      wptr_q   <= wptr_d;
      newest_q <= newest_d;
      acc_q    <= acc_d;
      yout_q   <= yout_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NTAP; i++) x_q[i] <= '0;
    end else if (accept) begin
      x_q[wptr_q] <= xin;
    end
  end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Self-checking bench: 16-tap default instance and a 5-tap wraparound instance.
module tb_fir_serial_mac;

  logic clk = 1'b0;
  logic rstn;
  logic en [2];
  logic signed [15:0] xin [2];
  logic rdy [2];
  logic valid [2];
  logic cwe [2];
  logic [3:0] caddr [2];
  logic signed [11:0] cdin [2];
  logic signed [31:0] yout0;
  logic signed [30:0] yout1;

  int nchk = 0;
  int nerr = 0;
  int nt [2] = '{16, 5};
  int hm [2][16];
  int xm [2][16];

  typedef struct {
    int     x;
    longint y;
  } vec_t;
  vec_t vt [17];

  always #5 clk = ~clk;

  fir_serial_mac u_dut16 (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en[0]),
    .xin       (xin[0]),
    .rdy       (rdy[0]),
    .coef_we   (cwe[0]),
    .coef_addr (caddr[0]),
    .coef_din  (cdin[0]),
    .valid     (valid[0]),
    .yout      (yout0)
  );

  fir_serial_mac #(.NTAP(5)) u_dut5 (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en[1]),
    .xin       (xin[1]),
    .rdy       (rdy[1]),
    .coef_we   (cwe[1]),
    .coef_addr (caddr[1][2:0]),
    .coef_din  (cdin[1]),
    .valid     (valid[1]),
    .yout      (yout1)
  );

  function automatic longint yo(int s);
    return (s == 0) ? longint'(yout0) : longint'(yout1);
  endfunction

  // Reference: y = sum h[k] * x[n-k] over the accepted-sample history.
  function automatic longint model(int s);
    longint acc = 0;
    for (int k = 0; k < nt[s]; k++)
      acc += longint'(hm[s][k]) * longint'(xm[s][k]);
    return acc;
  endfunction

  task automatic chk(string nm, longint got, longint exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic push(int s, int x);
    for (int k = 15; k > 0; k--) xm[s][k] = xm[s][k-1];
    xm[s][0] = x;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    for (int s = 0; s < 2; s++) begin
      en[s]  = 1'b0;
      cwe[s] = 1'b0;
      for (int k = 0; k < 16; k++) begin
        hm[s][k] = 0;
        xm[s][k] = 0;
      end
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic wcoef(int s, int k, int v);
    cwe[s]   = 1'b1;
    caddr[s] = 4'(k);
    cdin[s]  = 12'(v);
    @(posedge clk); #1;
    cwe[s] = 1'b0;
    if (k < nt[s]) hm[s][k] = v;
  endtask

  task automatic accept(int s, int x, bit we, int ka, int va);
    int i = 0;
    while (!rdy[s] && i < 100) begin
      @(posedge clk); #1;
      i++;
    end
    if (!rdy[s]) chk("rdy_timeout", 0, 1);
    en[s]    = 1'b1;
    xin[s]   = 16'(x);
    cwe[s]   = we;
    caddr[s] = 4'(ka);
    cdin[s]  = 12'(va);
    @(posedge clk); #1;
    en[s]  = 1'b0;
    cwe[s] = 1'b0;
    if (we && ka < nt[s]) hm[s][ka] = va;
    push(s, x);
  endtask

  task automatic wait_res(int s, int c0, string nm, longint exp);
    int c = c0;
    bit seen = 1'b0;
    while (!seen && c < 64) begin
      @(posedge clk); #1;
      c++;
      if (valid[s]) seen = 1'b1;
    end
    chk({nm, "_lat"}, seen ? c : -1, nt[s]);
    chk(nm, yo(s), exp);
    @(posedge clk); #1;
    chk({nm, "_pulse"}, valid[s], 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base, last_acc, run, nacc, vcnt;
    bit was_low;
    longint expq[$];

    for (int i = 0; i < 17; i++) begin
      vt[i].x = (i == 0) ? 1000 : 0;
      vt[i].y = (i < 16) ? longint'(1000 * (i + 1)) : 0;
    end
    for (int s = 0; s < 2; s++) begin
      xin[s]   = '0;
      caddr[s] = '0;
      cdin[s]  = '0;
    end
    @(posedge clk); #1;
    do_reset();

    for (int s = 0; s < 2; s++) begin
      chk("rst_valid", valid[s], 0);
      chk("rst_yout", yo(s), 0);
      chk("rst_rdy", rdy[s], 1);
    end

    // Impulse response, h[k] = k+1
    for (int k = 0; k < 16; k++) wcoef(0, k, k + 1);
    for (int i = 0; i < 17; i++) begin
      accept(0, vt[i].x, 1'b0, 0, 0);
      wait_res(0, 0, "impulse", vt[i].y);
    end

    // Streaming with en held and xin changing every cycle
    base = int'($urandom_range(0, 1000));
    last_acc = -1;
    run = 0;
    nacc = 0;
    was_low = 1'b0;
    en[0] = 1'b1;
    for (int cyc = 0; cyc < 85; cyc++) begin
      xin[0] = 16'(base + cyc);
      if (rdy[0]) begin
        if (was_low) chk("stream_rdy_low", run, 16);
        if (last_acc >= 0) chk("stream_spacing", cyc - last_acc, 17);
        last_acc = cyc;
        run = 0;
        was_low = 1'b0;
        nacc++;
        push(0, base + cyc);
        expq.push_back(model(0));
      end
      @(posedge clk); #1;
      if (!rdy[0]) begin
        run++;
        was_low = 1'b1;
      end
      if (valid[0]) begin
        if (expq.size() == 0) chk("stream_extra", 1, 0);
        else chk("stream_y", yo(0), expq.pop_front());
      end
    end
    en[0] = 1'b0;
    chk("stream_accepts", nacc, 5);
    chk("stream_pending", expq.size(), 0);

    // Full-scale accumulation
    do_reset();
    for (int k = 0; k < 16; k++) wcoef(0, k, -2048);
    for (int i = 0; i < 16; i++) begin
      accept(0, -32768, 1'b0, 0, 0);
      wait_res(0, 0, "fs_neg", model(0));
    end
    chk("fs_neg_final", yo(0), 64'sd1073741824);
    for (int k = 0; k < 16; k++) wcoef(0, k, 2047);
    for (int i = 0; i < 16; i++) begin
      accept(0, -32768, 1'b0, 0, 0);
      wait_res(0, 0, "fs_pos", model(0));
    end
    chk("fs_pos_final", yo(0), -64'sd1073217536);

    // Coefficient write timing
    do_reset();
    for (int k = 0; k < 16; k++) wcoef(0, k, k + 1);
    accept(0, 500, 1'b0, 0, 0);
    @(posedge clk); #1;
    cwe[0]   = 1'b1;
    caddr[0] = 4'd0;
    cdin[0]  = 12'sd100;
    @(posedge clk); #1;
    cwe[0] = 1'b0;
    wait_res(0, 2, "mac_write_dropped", 500);
    accept(0, 0, 1'b0, 0, 0);
    wait_res(0, 0, "after_dropped", 1000);
    accept(0, 300, 1'b1, 0, -7);
    wait_res(0, 0, "write_with_accept", -600);

    // Reset mid-run on the 16-tap instance; coefficients are lost
    accept(0, 700, 1'b0, 0, 0);
    repeat (5) @(posedge clk);
    #1 rstn = 1'b0;
    #2;
    chk("midrst_valid", valid[0], 0);
    chk("midrst_yout", yo(0), 0);
    chk("midrst_rdy", rdy[0], 1);
    do_reset();
    chk("midrst_rdy_rel", rdy[0], 1);
    for (int i = 0; i < 3; i++) begin
      accept(0, 1000 * (i + 1), 1'b0, 0, 0);
      wait_res(0, 0, "noreload", 0);
    end

    // 5-tap instance: wraparound against the reference model
    do_reset();
    for (int k = 0; k < 5; k++)
      wcoef(1, k, int'($urandom_range(0, 4095)) - 2048);
    for (int k = 5; k < 8; k++) wcoef(1, k, 1234);
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      accept(1, int'($urandom_range(0, 65535)) - 32768, 1'b0, 0, 0);
      wait_res(1, 0, "wrap", model(1));
    end

    // Reset at k=2 of a MAC: no valid, no partial yout
    accept(1, 1234, 1'b0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
    #2;
    chk("k2rst_yout", yo(1), 0);
    do_reset();
    chk("k2rst_rdy", rdy[1], 1);
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (valid[1]) vcnt++;
    end
    chk("k2rst_novalid", vcnt, 0);
    chk("k2rst_yout_rel", yo(1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end

endmodule
